logc_arbiter: RTL and testbench

Shares the single log-compression pipeline between NUM_CH envelope-detector channels in the ultrasound receive chain. Grants one channel per cycle in round-robin order and drives the compressor input. Tags each in-flight sample with its channel ID, matched to the compressor's fixed latency. Collects the compressed results in an output FIFO with valid/ready backpressure. Issue is gated by credits, so the compressor, which cannot stall, never overruns the FIFO.

---
 rtl/logc_pkg.sv | 18 +
 rtl/logc_arbiter_if.sv | 48 ++++
 rtl/logc_out_fifo.sv | 66 ++++++
 rtl/logc_arbiter.sv | 114 +++++++++++
 tb/tb_logc_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/logc_pkg.sv
// Shared types and defaults for the log-compression arbiter.
// LOGC_LATENCY must track the compressor's pipeline depth.
package logc_pkg;

    localparam int LOGC_NUM_CH     = 4;
    localparam int LOGC_CH_W       = $clog2(LOGC_NUM_CH);
    localparam int LOGC_DATA_WIDTH = 48;
    localparam int LOGC_COMP_WIDTH = LOGC_DATA_WIDTH / 2;
    localparam int LOGC_LATENCY    = 3;
    localparam int LOGC_FIFO_DEPTH = 8;

    // One entry of the tag pipeline that follows a sample through the compressor.
    typedef struct packed {
        logic                 valid;
        logic [LOGC_CH_W-1:0] ch;
    } logc_tag_t;

endpackage

// File: rtl/logc_arbiter_if.sv
// Bundle of the channel request, compressor and output stream signals.
// master is the arbiter's view; slave is the surrounding datapath.
interface logc_arbiter_if #(
    parameter int NUM_CH     = logc_pkg::LOGC_NUM_CH,
    parameter int DATA_WIDTH = logc_pkg::LOGC_DATA_WIDTH,
    parameter int COMP_WIDTH = logc_pkg::LOGC_COMP_WIDTH
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]            in_ready;
    logic                         logc_valid;
    logic [DATA_WIDTH-1:0]        logc_data;
    logic [COMP_WIDTH-1:0]        logc_comp;
    logic                         out_valid;
    logic                         out_ready;
    logic [CH_W-1:0]              out_ch;
    logic [COMP_WIDTH-1:0]        out_data;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output logc_valid,
        output logc_data,
        input  logc_comp,
        output out_valid,
        input  out_ready,
        output out_ch,
        output out_data
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  logc_valid,
        input  logc_data,
        output logc_comp,
        input  out_valid,
        output out_ready,
        input  out_ch,
        input  out_data
    );

endinterface

// File: rtl/logc_out_fifo.sv
// Synchronous FIFO holding {ch, compressed sample} pairs.
// Push and pop may coincide at any occupancy; the head comes straight from storage flops.
module logc_out_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop at full frees the slot the simultaneous push lands in.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n) !(push && full && !do_pop)
    );

endmodule

// File: rtl/logc_arbiter.sv
// Round-robin arbiter sharing one log compressor among envelope channels.
// Credits cover FIFO occupancy plus in-flight tags so the unstallable compressor never overruns.
module logc_arbiter #(
    parameter int NUM_CH       = logc_pkg::LOGC_NUM_CH,
    parameter int DATA_WIDTH   = logc_pkg::LOGC_DATA_WIDTH,
    parameter int COMP_WIDTH   = DATA_WIDTH / 2,
    parameter int LOGC_LATENCY = logc_pkg::LOGC_LATENCY,
    parameter int FIFO_DEPTH   = logc_pkg::LOGC_FIFO_DEPTH
) (
    input logic            clk,
    input logic            reset,
    logc_arbiter_if.master bus
);

    import logc_pkg::*;

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int STAGES = LOGC_LATENCY + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] ch_data [NUM_CH];
    logic [CH_W-1:0]       ptr;
    logic [CH_W-1:0]       cand;
    logic [CH_W-1:0]       grant_idx;
    logic [NUM_CH-1:0]     grant;
    logic                  found;
    logic                  issue_ok;
    logic                  accept;
    int                    inflight;
    logc_tag_t             tags [STAGES];
    logic [DATA_WIDTH-1:0] logc_data_q;
    logic [CNT_W-1:0]      fifo_count;
    logic                  empty;
    logic                  pop;
    logic [CH_W+COMP_WIDTH-1:0] head;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
        assign ch_data[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Pick the first requester after the pointer, scanning upward with wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!found && bus.in_valid[cand]) begin
                found       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    // Count samples still travelling through the compressor.
    always_comb begin
        inflight = 0;
        for (int k = 0; k < STAGES; k++) begin
            inflight = inflight + int'(tags[k].valid);
        end
    end

    // Conservative credit: a pop this cycle is only seen next cycle.
    assign issue_ok     = (int'(fifo_count) + inflight) < FIFO_DEPTH;
    assign accept       = reset && issue_ok && found;
    assign bus.in_ready = accept ? grant : '0;

    // Issue register toward the compressor and the channel tag shift register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr         <= CH_W'(NUM_CH - 1);
            logc_data_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                tags[k] <= '0;
            end
        end else begin
            tags[0].valid <= accept;
            tags[0].ch    <= accept ? grant_idx : '0;
            for (int k = 1; k < STAGES; k++) begin
                tags[k] <= tags[k-1];
            end
            if (accept) begin
                ptr         <= grant_idx;
                logc_data_q <= ch_data[grant_idx];
            end
        end
    end

    assign bus.logc_valid = tags[0].valid;
    assign bus.logc_data  = logc_data_q;

    assign pop = !empty && bus.out_ready;

    logc_out_fifo #(
        .WIDTH (CH_W + COMP_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (tags[STAGES-1].valid),
        .wdata ({tags[STAGES-1].ch, bus.logc_comp}),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .count (fifo_count)
    );

    assign bus.out_valid = !empty;
    assign bus.out_ch    = head[CH_W+COMP_WIDTH-1:COMP_WIDTH];
    assign bus.out_data  = head[COMP_WIDTH-1:0];

endmodule

// File: tb/tb_logc_arbiter.sv
// Directed bench for logc_arbiter with a 3-deep compressor model.
// Inputs change and outputs are sampled on the falling edge.
module tb_logc_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logc_arbiter_if bus();

    logc_arbiter dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    function automatic logic [23:0] comp_f(input logic [47:0] d);
        return d[47:24] ^ d[23:0];
    endfunction

    // Compressor: fixed three-edge latency from logc_data to logc_comp.
    logic [23:0] c1, c2, c3;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c1 <= '0;
            c2 <= '0;
            c3 <= '0;
        end else begin
            c1 <= comp_f(bus.logc_data);
            c2 <= c1;
            c3 <= c2;
        end
    end
    assign bus.logc_comp = c3;

    int errors = 0;
    int checks = 0;
    logic [47:0] dat [4];
    logic [47:0] saved;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load();
        for (int i = 0; i < 4; i++) begin
            bus.in_data[i*48 +: 48] = dat[i];
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input int ch, input logic [47:0] d);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        check({tag, "_ch"}, 64'(bus.out_ch), 64'(ch));
        check({tag, "_data"}, 64'(bus.out_data), 64'(comp_f(d)));
    endtask

    initial begin
        dat[0] = 48'h0000AA_111111;
        dat[1] = 48'h0001BB_222222;
        dat[2] = 48'h0002CC_333333;
        dat[3] = 48'h0003DD_444444;
        load();
        rst_n         = 1'b0;
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;
        repeat (2) cyc();
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_logc_valid", 64'(bus.logc_valid), 64'(0));
        check("rst_logc_data", 64'(bus.logc_data), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_ch", 64'(bus.out_ch), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        rst_n        = 1'b1;
        bus.in_valid = 4'h0;

        // Round robin, all channels requesting, one sample per cycle.
        for (int n = 0; n < 18; n++) begin
            cyc();
            bus.in_valid = (n < 12) ? 4'hF : 4'h0;
            #1;
            if (n < 12)
                check("rr_grant", 64'(bus.in_ready), 64'(1) << (n % 4));
            if (n >= 5 && n <= 16)
                check_out("rr_out", (n - 5) % 4, dat[(n - 5) % 4]);
            if (n == 17)
                check("rr_drained", 64'(bus.out_valid), 64'(0));
        end

        // Mid-stream reset discards everything and restarts priority at ch0.
        for (int n = 0; n < 6; n++) begin
            cyc();
            bus.in_valid = 4'hF;
        end
        cyc();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("mid_rst_logc_valid", 64'(bus.logc_valid), 64'(0));
        check("mid_rst_logc_data", 64'(bus.logc_data), 64'(0));
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_out_ch", 64'(bus.out_ch), 64'(0));
        check("mid_rst_out_data", 64'(bus.out_data), 64'(0));
        cyc();
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 64'(bus.in_ready), 64'(1));
        cyc();
        bus.in_valid = 4'h0;
        #1;
        check("post_rst_logc_valid", 64'(bus.logc_valid), 64'(1));
        check("post_rst_logc_data", 64'(bus.logc_data), 64'(dat[0]));
        repeat (3) cyc();
        #1;
        check("post_rst_no_stale", 64'(bus.out_valid), 64'(0));
        cyc();
        #1;
        check_out("post_rst_out", 0, dat[0]);
        cyc();
        #1;
        check("post_rst_empty", 64'(bus.out_valid), 64'(0));

        // Single channel 2 with data 0x1000.
        saved  = dat[2];
        dat[2] = 48'h1000;
        load();
        cyc();
        bus.in_valid = 4'b0100;
        #1;
        check("single_grant", 64'(bus.in_ready), 64'(4'b0100));
        cyc();
        bus.in_valid = 4'h0;
        #1;
        check("single_logc_valid", 64'(bus.logc_valid), 64'(1));
        check("single_logc_data", 64'(bus.logc_data), 64'(48'h1000));
        cyc();
        #1;
        check("single_logc_idle", 64'(bus.logc_valid), 64'(0));
        check("single_logc_hold", 64'(bus.logc_data), 64'(48'h1000));
        repeat (2) cyc();
        #1;
        check("single_not_yet", 64'(bus.out_valid), 64'(0));
        cyc();
        #1;
        check_out("single_out", 2, 48'h1000);
        dat[2] = saved;
        load();

        // Sparse requests: idle channels are skipped.
        cyc();
        bus.in_valid = 4'b1000;
        #1;
        check("sparse_ch3", 64'(bus.in_ready), 64'(4'b1000));
        cyc();
        bus.in_valid = 4'b0010;
        #1;
        check("sparse_ch1", 64'(bus.in_ready), 64'(4'b0010));
        cyc();
        bus.in_valid = 4'b1010;
        #1;
        check("sparse_pair_a", 64'(bus.in_ready), 64'(4'b1000));
        cyc();
        #1;
        check("sparse_pair_b", 64'(bus.in_ready), 64'(4'b0010));
        cyc();
        bus.in_valid = 4'h0;
        repeat (8) cyc();

        // Backpressure: eight credits, then stall with a stable head.
        for (int n = 0; n < 11; n++) begin
            cyc();
            bus.out_ready = 1'b0;
            bus.in_valid  = 4'hF;
            #1;
            if (n < 8)
                check("bp_grant", 64'(bus.in_ready), 64'(1) << ((n + 2) % 4));
            else
                check("bp_stall", 64'(bus.in_ready), 64'(0));
            if (n == 8 || n == 10)
                check_out("bp_head", 2, dat[2]);
        end
        cyc();
        bus.out_ready = 1'b1;
        #1;
        check("bp_pop_no_credit", 64'(bus.in_ready), 64'(0));
        check("bp_head_last", 64'(bus.out_ch), 64'(2));
        cyc();
        bus.out_ready = 1'b0;
        #1;
        check("bp_resume", 64'(bus.in_ready), 64'(4'b0100));
        check("bp_next_head", 64'(bus.out_ch), 64'(3));
        cyc();
        bus.in_valid = 4'h0;
        for (int j = 0; j < 8; j++) begin
            cyc();
            bus.out_ready = 1'b1;
            #1;
            check_out("bp_drain", (3 + j) % 4, dat[(3 + j) % 4]);
        end
        cyc();
        #1;
        check("bp_drained", 64'(bus.out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
